// File: rtl/sram_controller.sv
// Splits each 32-bit data-memory load/store into two sequential 16-bit SRAM
// accesses (low half, then high half) and freezes the pipeline until done.
module sram_controller #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MEM_BASE      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              op_wr_r;
    logic [16:0]       word_r;
    logic [31:0]       wdata_r;
    logic [31:0]       read_data_r;
    logic [31:0]       off_s;
    logic              req_s;
    logic              last_s;
    logic              dq_oe_s;
    logic [15:0]       dq_out_s;
    logic              unused_off_bits_s;

    assign req_s  = rd_en | wr_en;
    assign last_s = (cnt_r == CNT_W'(ACCESS_CYCLES - 1));
    // Wraparound is intentional: addresses below MEM_BASE alias high words.
    assign off_s  = address - 32'(MEM_BASE);
    assign unused_off_bits_s = ^{off_s[31:19], off_s[1:0]};

    assign SRAM_DQ   = dq_oe_s ? dq_out_s : 16'bz;
    assign read_data = read_data_r;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // State register plus latched request, counter and captured load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            op_wr_r     <= 1'b0;
            word_r      <= 17'd0;
            wdata_r     <= 32'd0;
            read_data_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (req_s) begin
                        op_wr_r <= wr_en;
                        word_r  <= off_s[18:2];
                        wdata_r <= write_data;
                    end
                end
                LO: begin
                    cnt_r <= last_s ? '0 : cnt_r + CNT_W'(1);
                    if (!op_wr_r && last_s) begin
                        read_data_r[15:0] <= SRAM_DQ;
                    end
                end
                HI: begin
                    cnt_r <= last_s ? '0 : cnt_r + CNT_W'(1);
                    if (!op_wr_r && last_s) begin
                        read_data_r[31:16] <= SRAM_DQ;
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    // Next-state logic; DONE never re-accepts a request.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) next_state_s = LO;
                else       next_state_s = IDLE;
            end
            LO: begin
                if (last_s) next_state_s = HI;
                else        next_state_s = LO;
            end
            HI: begin
                if (last_s) next_state_s = DONE;
                else        next_state_s = HI;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Bus strobes, data drive and ready decoded from the registered state.
    always_comb begin
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_ADDR = {word_r, 1'b0};
        dq_oe_s   = 1'b0;
        dq_out_s  = wdata_r[15:0];
        case (state_r)
            IDLE: ready = ~req_s;
            LO: begin
                SRAM_WE_N = ~op_wr_r;
                SRAM_OE_N = op_wr_r;
                dq_oe_s   = op_wr_r;
            end
            HI: begin
                SRAM_WE_N = ~op_wr_r;
                SRAM_OE_N = op_wr_r;
                SRAM_ADDR = {word_r, 1'b1};
                dq_oe_s   = op_wr_r;
                dq_out_s  = wdata_r[31:16];
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: per-cycle bus/ready expectations are
// queued as stimulus is driven and compared on the falling clock edge.
module tb_sram_controller;

    localparam int AC       = 2;
    localparam int MEM_BASE = 1024;

    typedef struct packed {
        logic        ready;
        logic        we_n;
        logic        oe_n;
        logic        chk_addr;
        logic        chk_dq;
        logic        chk_rd;
        logic [17:0] addr;
        logic [15:0] dq;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    logic [15:0] mem    [0:15];
    logic [15:0] shadow [0:15];
    logic [31:0] exp_rd;
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    sram_controller #(.ACCESS_CYCLES(AC), .MEM_BASE(MEM_BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: drives the bus on output enable, stores on write enable.
    assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[3:0]] : 16'bz;
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: one queued expectation per clock cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ready", {31'd0, ready}, {31'd0, e.ready});
            check("we_n", {31'd0, sram_we_n}, {31'd0, e.we_n});
            check("oe_n", {31'd0, sram_oe_n}, {31'd0, e.oe_n});
            check("ce_ub_lb", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
            if (e.chk_addr) check("addr", {14'd0, sram_addr}, {14'd0, e.addr});
            if (e.chk_dq)   check("dq", {16'd0, sram_dq}, {16'd0, e.dq});
            if (e.chk_rd)   check("read_data", read_data, e.rd);
        end
    end

    function automatic exp_t idle_exp(input logic rdy);
        exp_t e;
        e = '0;
        e.ready  = rdy;
        e.we_n   = 1'b1;
        e.oe_n   = 1'b1;
        e.chk_dq = 1'b1;
        e.dq     = 16'bz;
        return e;
    endfunction

    // One access; abort_at >= 0 asserts rst during that cycle and stops there.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input bit hold, input int abort_at);
        logic [31:0] off;
        logic [16:0] word;
        logic [3:0]  lo_i;
        exp_t        e;
        bit          aborted;
        off     = addr - 32'(MEM_BASE);
        word    = off[18:2];
        lo_i    = {word[2:0], 1'b0};
        aborted = 1'b0;
        for (int k = 0; k <= 2*AC+1; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                rd_en = rd; wr_en = wr; address = addr; write_data = wd;
            end else if (!hold) begin
                rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
            end
            e = idle_exp(1'b0);
            if (k >= 1 && k <= 2*AC) begin
                e.we_n     = ~wr;
                e.oe_n     = wr;
                e.chk_addr = 1'b1;
                e.addr     = {word, (k > AC) ? 1'b1 : 1'b0};
                e.chk_dq   = wr;
                e.dq       = (k > AC) ? wd[31:16] : wd[15:0];
            end else if (k == 2*AC+1) begin
                e.ready  = 1'b1;
                e.chk_rd = 1'b1;
                if (!wr) exp_rd = {shadow[lo_i + 4'd1], shadow[lo_i]};
                e.rd     = exp_rd;
            end
            exp_q.push_back(e);
            if (k == abort_at) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (wr && !aborted) begin
            shadow[lo_i]        = wd[15:0];
            shadow[lo_i + 4'd1] = wd[31:16];
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rd_en = 1'b0; wr_en = 1'b0;
            exp_q.push_back(idle_exp(1'b1));
        end
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e          = idle_exp(1'b1);
        e.chk_addr = 1'b1;
        e.addr     = 18'd0;
        e.chk_rd   = 1'b1;
        e.rd       = 32'd0;
        exp_rd     = 32'd0;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        address = 32'd0; write_data = 32'd0; exp_rd = 32'd0;
        for (int i = 0; i < 16; i++) shadow[i] = 16'd0;

        // Reset idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_reset_exp();
        idle_cycles(1);

        // Store 0xDEADBEEF to 1028 (half-words 2/3), then load it back
        do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, -1);
        idle_cycles(1);
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, -1);
        idle_cycles(1);

        // Back-to-back: store, then a load held high from the DONE cycle on
        do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0, -1);
        rd_en = 1'b1; address = 32'd1024;
        do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, -1);
        rd_en = 1'b0;
        idle_cycles(1);

        // Both enables high is a write; then a one-cycle read pulse
        do_access(1'b1, 1'b1, 32'd1032, 32'h0000CAFE, 1'b0, -1);
        idle_cycles(2);
        do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, -1);
        idle_cycles(1);

        // Reset during the first HI cycle of a store, then a normal load
        do_access(1'b0, 1'b1, 32'd1040, 32'hA5A5_5A5A, 1'b0, 3);
        @(posedge clk); #1;
        rst = 1'b0;
        push_reset_exp();
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, -1);
        idle_cycles(2);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the MEM stage and serves every data-memory access.
- Turns one 32-bit load or store into two sequential 16-bit accesses on the external SRAM bus: low half first, then high half.
- Holds ready low while an access is in flight. The MEM stage exports the inverse of ready as SRAM_freeze, which stalls the whole pipeline.

Parameters:
- ACCESS_CYCLES, 2: cycles each 16-bit half-access occupies on the SRAM bus; legal range is 1 or more.
- MEM_BASE, 1024: byte address of data-memory word 0; subtracted from the request address.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  load request from the MEM stage
- wr_en  in  1  store request from the MEM stage
- address  in  32  byte address, from the ALU result
- write_data  in  32  store data, from reg2
- read_data  out  32  load result; valid while ready=1 in DONE after a read
- ready  out  1  high when no access is outstanding; low means freeze the pipeline
- SRAM_DQ  inout  16  external data bus
- SRAM_ADDR  out  18  external half-word address
- SRAM_UB_N  out  1  upper byte enable, active-low
- SRAM_LB_N  out  1  lower byte enable, active-low
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_CE_N  out  1  chip enable, active-low
- SRAM_OE_N  out  1  output enable, active-low

Behaviour:
- Reset and synchronicity:
  - Reset is synchronous, active-high, on the rising edge of clk.
  - Reset drives state to IDLE, cnt=0, read_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ high-Z and SRAM_ADDR=0.
  - SRAM_CE_N, SRAM_UB_N and SRAM_LB_N are constant 0.
- Address map:
  - off = address - MEM_BASE, in 32-bit wraparound arithmetic.
  - word = off[18:2].
  - The low half uses SRAM_ADDR = {word[16:0],0}; the high half uses {word[16:0],1}.
  - off[1:0] are ignored, so unaligned accesses are not supported.
- State machine (IDLE, LO, HI, DONE):
  - IDLE: ready = ~(rd_en|wr_en). On (rd_en|wr_en) the block latches op (write if wr_en, else read), word and write_data, clears cnt, and moves to LO.
  - LO: runs for ACCESS_CYCLES cycles, then moves to HI with cnt cleared.
  - HI: runs for ACCESS_CYCLES cycles, then moves to DONE.
  - DONE: lasts one cycle with ready=1, then returns to IDLE unconditionally.
  - cnt counts 0..ACCESS_CYCLES-1 within LO and HI.
- Latency:
  - The request is first seen in cycle 0.
  - ready=0 from cycle 0 through cycle 2*ACCESS_CYCLES.
  - ready=1 in cycle 2*ACCESS_CYCLES+1 (DONE). The pipeline advances on that cycle's closing edge.
  - With the default ACCESS_CYCLES=2, DONE is cycle 5, giving a 5-cycle freeze.
- Write:
  - SRAM_WE_N=0 and SRAM_OE_N=1 throughout LO and HI.
  - SRAM_DQ is driven with write_data[15:0] in LO and write_data[31:16] in HI.
  - SRAM_DQ returns to high-Z in DONE and IDLE.
  - read_data is unchanged by a write.
- Read:
  - SRAM_OE_N=0 and SRAM_WE_N=1 throughout LO and HI; SRAM_DQ is high-Z.
  - On the last cycle of LO (cnt=ACCESS_CYCLES-1) the block registers SRAM_DQ into read_data[15:0].
  - On the last cycle of HI it registers SRAM_DQ into read_data[31:16].
  - read_data holds its value until the next read overwrites it.
- Boundary conditions:
  - rd_en and wr_en both high: treated as a write.
  - Request dropped mid-access: the access still completes, using the latched op, address and data.
  - Inputs changing mid-access: ignored; only the values latched in IDLE are used.
  - Request still high in DONE: not re-accepted in DONE. Any request present in the following IDLE cycle is a new access; back-to-back accesses cost one IDLE cycle with ready=0.
  - Reset in any state: next state is IDLE with all reset values applied. A half-written store is abandoned, with no partial-write recovery.
  - Address below MEM_BASE: wraps per the map above; no error is flagged.

Test Plan:
- Reset idle: assert rst for 2 cycles with no requests -> ready=1, read_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z.
- Store: wr_en=1, address=1028, write_data=0xDEADBEEF, ACCESS_CYCLES=2 -> SRAM_ADDR=2 with DQ=0xBEEF for 2 cycles, then SRAM_ADDR=3 with DQ=0xDEAD for 2 cycles, WE_N=0 across all 4; ready=0 in cycles 0-4 and 1 in cycle 5.
- Load: SRAM model preloaded with half-word 2=0xBEEF and 3=0xDEAD; rd_en=1, address=1028 -> OE_N=0 during LO and HI; read_data=0xDEADBEEF with ready=1 in cycle 5.
- Back-to-back: store to 1024 of 0x12345678, then load from 1024 held continuously -> load starts after one IDLE cycle and returns 0x12345678; ready pattern 0,0,0,0,0,1,0,0,0,0,0,1.
- Simultaneous and dropped requests: rd_en=wr_en=1 at address 1032 with 0x0000CAFE -> write performed at SRAM_ADDR 4 and 5. Then rd_en pulsed for 1 cycle only -> full read still completes, ready=1 at cycle 5.
- Reset mid-operation: rst in HI cycle 3 of a store -> next cycle IDLE, ready=1, WE_N=1, DQ=Z; a subsequent load from 1028 completes normally in 6 cycles.
